// File: rtl/sound_serializer.sv
// Parallel-to-serial feeder: accepts samples over valid/ready and shifts them out MSB-first,
// each bit held CLK_DIV clocks. Define SOUND_SER_PARITY_EN to append an even-parity bit.
module sound_serializer #(
    parameter int   DATA_W     = 8,
    parameter int   CLK_DIV    = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              Clock,
    input  logic              Areset,
    input  logic [DATA_W-1:0] SampleData,
    input  logic              SampleValid,
    output logic              SampleReady,
    output logic              SerialOut,
    output logic              BitStrobe,
    output logic              WordDone,
    output logic              Busy
);

`ifdef SOUND_SER_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(NBITS + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(NBITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [NBITS-2:0]   shreg, shreg_nxt;
    logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic               serial_nxt, strobe_nxt, done_nxt;
    logic [NBITS-1:0]   load_word;
    logic               accept;

    // Word as it leaves the block, MSB first; parity is captured together with the data.
`ifdef SOUND_SER_PARITY_EN
    assign load_word = {SampleData, ^SampleData};
`else
    assign load_word = SampleData;
`endif

    assign SampleReady = !Areset &&
                         (state == IDLE || (state == SHIFT && div_cnt == '0 && bit_cnt == '0));
    assign accept      = SampleValid && SampleReady;
    assign Busy        = (state == SHIFT);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        div_cnt_nxt = div_cnt;
        bit_cnt_nxt = bit_cnt;
        serial_nxt  = SerialOut;
        strobe_nxt  = 1'b0;
        done_nxt    = 1'b0;

        if (accept) begin
            // Accept in SHIFT only happens on the last cycle of a word, which also completes it.
            done_nxt    = (state == SHIFT);
            serial_nxt  = load_word[NBITS-1];
            shreg_nxt   = load_word[NBITS-2:0];
            bit_cnt_nxt = BIT_LOAD;
            div_cnt_nxt = DIV_LOAD;
            strobe_nxt  = 1'b1;
            state_nxt   = SHIFT;
        end else if (state == SHIFT) begin
            if (div_cnt != '0) begin
                div_cnt_nxt = div_cnt - DIV_W'(1);
            end else if (bit_cnt != '0) begin
                serial_nxt  = shreg[NBITS-2];
                shreg_nxt   = shreg << 1;
                bit_cnt_nxt = bit_cnt - BIT_W'(1);
                div_cnt_nxt = DIV_LOAD;
                strobe_nxt  = 1'b1;
            end else begin
                done_nxt    = 1'b1;
                serial_nxt  = IDLE_LEVEL;
                state_nxt   = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock) begin
        if (Areset) begin
            state     <= IDLE;
            SerialOut <= IDLE_LEVEL;
            BitStrobe <= 1'b0;
            WordDone  <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            SerialOut <= serial_nxt;
            BitStrobe <= strobe_nxt;
            WordDone  <= done_nxt;
            div_cnt   <= div_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    // NOTE: the shift register is left unreset; it is always reloaded on accept before any bit is used.
    always_ff @(posedge Clock) begin
        shreg <= shreg_nxt;
    end

endmodule

// File: tb/tb_sound_serializer.sv
// Directed bench for sound_serializer: CLK_DIV=4 instance plus a CLK_DIV=1 instance.
// Parity expectations are enabled when SOUND_SER_PARITY_EN is defined.
module tb_sound_serializer;

`ifdef SOUND_SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data, data1;
    logic       valid, valid1;
    logic       ready, serial, strobe, done, busy;
    logic       ready1, serial1, strobe1, done1, busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sound_serializer #(.DATA_W(8), .CLK_DIV(DIV), .IDLE_LEVEL(1'b0)) dut (
        .Clock(clk), .Areset(rst), .SampleData(data), .SampleValid(valid),
        .SampleReady(ready), .SerialOut(serial), .BitStrobe(strobe),
        .WordDone(done), .Busy(busy)
    );

    sound_serializer #(.DATA_W(8), .CLK_DIV(1), .IDLE_LEVEL(1'b0)) dut1 (
        .Clock(clk), .Areset(rst), .SampleData(data1), .SampleValid(valid1),
        .SampleReady(ready1), .SerialOut(serial1), .BitStrobe(strobe1),
        .WordDone(done1), .Busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one word on the CLK_DIV=4 instance, starting just after its accept edge and
    // ending just after the edge that follows its last cycle.
    task automatic check_word(input string tag, input logic [7:0] w, input logic par,
                              input logic done_first, input logic drop_valid);
        logic [8:0] bits;
        bits = {w, par};
        for (int c = 0; c < NB * DIV; c++) begin
            check({tag, "_serial"}, serial, bits[8 - c / DIV]);
            check({tag, "_strobe"}, strobe, (c % DIV) == 0);
            check({tag, "_done"},   done,   done_first && c == 0);
            check({tag, "_busy"},   busy,   1'b1);
            check({tag, "_ready"},  ready,  c == NB * DIV - 1);
            if (drop_valid && c == NB * DIV - 1) valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; data = 8'h00; valid1 = 1'b0; data1 = 8'h00;

        // Reset held for two cycles.
        tick(); tick();
        check("rst_serial", serial, 1'b0);
        check("rst_strobe", strobe, 1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_busy",   busy,   1'b0);
        check("rst_ready",  ready,  1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", ready, 1'b1);
        tick(); tick();
        check("idle_strobe", strobe, 1'b0);
        check("idle_serial", serial, 1'b0);

        // Single word 8'hA5, WordDone NB*4 cycles after accept.
        data = 8'hA5; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_word("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        check("a5_wdone",    done,   1'b1);
        check("a5_idle_ser", serial, 1'b0);
        check("a5_idle_bsy", busy,   1'b0);
        check("a5_idle_stb", strobe, 1'b0);
        tick();
        check("a5_done_pulse", done,  1'b0);
        check("a5_ready_back", ready, 1'b1);

        // Gapless 8'hFF then 8'h00 with valid held high.
        data = 8'hFF; valid = 1'b1;
        tick();
        data = 8'h00;
        check_word("ff", 8'hFF, 1'b0, 1'b0, 1'b0);
        check_word("z0", 8'h00, 1'b0, 1'b1, 1'b1);
        check("z0_wdone", done, 1'b1);
        check("z0_busy",  busy, 1'b0);
        check("z0_ser",   serial, 1'b0);
        tick();

        // Reset after 3 bits of 8'hF0 abandons the word.
        data = 8'hF0; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 0; c < 3 * DIV; c++) begin
            check("f0_serial", serial, 1'b1);
            tick();
        end
        rst = 1'b1;
        #1;
        check("midrst_ready", ready, 1'b0);
        tick();
        rst = 1'b0;
        check("midrst_busy",   busy,   1'b0);
        check("midrst_serial", serial, 1'b0);
        check("midrst_strobe", strobe, 1'b0);
        for (int c = 0; c < NB * DIV; c++) begin
            check("midrst_nodone", done, 1'b0);
            tick();
        end
        data = 8'h81; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_word("w81", 8'h81, 1'b0, 1'b0, 1'b0);
        check("w81_wdone", done, 1'b1);
        tick();

`ifdef SOUND_SER_PARITY_EN
        // Parity bit follows the LSB: 8'h07 -> 1, 8'h03 -> 0.
        data = 8'h07; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_word("p07", 8'h07, 1'b1, 1'b0, 1'b0);
        check("p07_wdone", done, 1'b1);
        tick();
        data = 8'h03; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_word("p03", 8'h03, 1'b0, 1'b0, 1'b0);
        check("p03_wdone", done, 1'b1);
        tick();
`endif

        // CLK_DIV=1: one bit per cycle, strobe high throughout.
        data1 = 8'h3C; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        begin
            logic [8:0] bits1;
            bits1 = {8'h3C, 1'b0};
            for (int c = 0; c < NB; c++) begin
                check("d1_serial", serial1, bits1[8 - c]);
                check("d1_strobe", strobe1, 1'b1);
                check("d1_done",   done1,   1'b0);
                check("d1_busy",   busy1,   1'b1);
                tick();
            end
        end
        check("d1_wdone",  done1,   1'b1);
        check("d1_strobe_end", strobe1, 1'b0);
        check("d1_ser_end", serial1, 1'b0);
        check("d1_busy_end", busy1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
